// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcodes and the result-FIFO entry layout.
// Defining ALU_RESULT_FLAGS_EN adds zero/negative flag bits to every FIFO entry.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_SEL_W = 4;

    localparam logic [3:0] OP_NOT_A     = 4'b0000;
    localparam logic [3:0] OP_NOT_B     = 4'b0001;
    localparam logic [3:0] OP_AND       = 4'b0010;
    localparam logic [3:0] OP_NAND      = 4'b0011;
    localparam logic [3:0] OP_OR        = 4'b0100;
    localparam logic [3:0] OP_NOR       = 4'b0101;
    localparam logic [3:0] OP_XOR       = 4'b0110;
    localparam logic [3:0] OP_XNOR      = 4'b0111;
    localparam logic [3:0] OP_DEC_A     = 4'b1000;
    localparam logic [3:0] OP_INC_B     = 4'b1001;
    localparam logic [3:0] OP_DEC_B     = 4'b1010;
    localparam logic [3:0] OP_ADD       = 4'b1011;
    localparam logic [3:0] OP_B_MINUS_A = 4'b1100;

`ifdef ALU_RESULT_FLAGS_EN
    localparam int ALU_FLAG_W = 2;
`else
    localparam int ALU_FLAG_W = 0;
`endif

    // Entry layout, MSB first: {flags (optional), sel, res}
    localparam int ALU_ENTRY_W = ALU_WIDTH + ALU_SEL_W + ALU_FLAG_W;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

endpackage

// File: rtl/alu_fifo_mem.sv
// Register-array storage for the ALU result FIFO: synchronous write, combinational read.
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = ALU_ENTRY_W,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    // No reset: contents are only observed through valid pointers.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// In-order result FIFO behind the 4-bit ALU with valid/ready on both sides.
// Defining ALU_RESULT_FLAGS_EN adds the out_zero/out_neg outputs.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEL_W = ALU_SEL_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_res,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_res,
    output logic [SEL_W-1:0]         out_sel,
`ifdef ALU_RESULT_FLAGS_EN
    output logic                     out_zero,
    output logic                     out_neg,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = WIDTH + SEL_W + ALU_FLAG_W;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // in_ready/out_valid come from registered occupancy only, never from the other side.
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    fill_state_e        fill_state;

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (count_q == '0) begin
            fill_state = FILL_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            fill_state = FILL_FULL;
        end
    end

    assign in_ready  = (fill_state != FILL_FULL);
    assign out_valid = (fill_state != FILL_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            // Flush wins over any transfer offered in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    assign wr_entry = {(in_res == '0), in_res[WIDTH-1], in_sel, in_res};
`else
    assign wr_entry = {in_sel, in_res};
`endif

    alu_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .PTR_W   (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign out_res = out_valid ? rd_entry[WIDTH-1:0] : '0;
    assign out_sel = out_valid ? rd_entry[WIDTH+SEL_W-1:WIDTH] : '0;
`ifdef ALU_RESULT_FLAGS_EN
    assign out_zero = out_valid & rd_entry[ENTRY_W-1];
    assign out_neg  = out_valid & rd_entry[ENTRY_W-2];
`endif
    assign count = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized self-checking bench for alu_result_fifo against a queue-based reference.
// Covers the ALU_RESULT_FLAGS_EN outputs when that macro is defined.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int SEL_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_res;
    logic [SEL_W-1:0] in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [SEL_W-1:0] out_sel;
    logic [CNT_W-1:0] count;
`ifdef ALU_RESULT_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
`endif

    int vectors;
    int miscompares;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    alu_result_fifo #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sel   (out_sel),
`ifdef ALU_RESULT_FLAGS_EN
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`endif
        .count     (count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [SEL_W+WIDTH-1:0] head;
        bit                     nonempty;
        nonempty = (exp_q.size() != 0);
        head     = nonempty ? exp_q[0] : '0;
        check_eq({tag, ".count"},     32'(count),     32'(exp_q.size()));
        check_eq({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() != DEPTH));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(nonempty));
        check_eq({tag, ".out_res"},   32'(out_res),   32'(head[WIDTH-1:0]));
        check_eq({tag, ".out_sel"},   32'(out_sel),   32'(head[WIDTH+SEL_W-1:WIDTH]));
`ifdef ALU_RESULT_FLAGS_EN
        check_eq({tag, ".out_zero"},  32'(out_zero),  32'(nonempty && head[WIDTH-1:0] == 0));
        check_eq({tag, ".out_neg"},   32'(out_neg),   32'(nonempty && head[WIDTH-1]));
`endif
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input bit v, input logic [WIDTH-1:0] r, input logic [SEL_W-1:0] s,
                         input bit rdy, input bit clr);
        in_valid  = v;
        in_res    = r;
        in_sel    = s;
        out_ready = rdy;
        clear     = clr;
    endtask

    // One clock: check outputs mid-cycle, then advance the reference model.
    task automatic cycle(input string tag);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        check_outputs(tag);
        do_push = in_valid && (exp_q.size() < DEPTH);
        do_pop  = out_ready && (exp_q.size() > 0);
        @(posedge clk);
        if (clear) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_sel, in_res});
        end
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle, then asynchronous reset with 3 entries held
        cycle("reset_idle");
        cycle("reset_idle2");
        for (int i = 0; i < 3; i++) begin
            drive(1, WIDTH'(i + 7), OP_XOR, 0, 0);
            cycle("fill3");
        end
        drive(0, '0, '0, 0, 0);
        check_eq("pre_rst.count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst.count",     32'(count),     32'd0);
        check_eq("async_rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst.out_res",   32'(out_res),   32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst");

        // Two pushes held with out_ready low, then drained in order
        drive(1, 4'hA, OP_AND, 0, 0);
        cycle("push_a");
        drive(1, 4'h3, OP_ADD, 0, 0);
        cycle("push_3");
        drive(0, '0, '0, 0, 0);
        repeat (3) cycle("hold_head");
        drive(0, '0, '0, 1, 0);
        repeat (3) cycle("drain_two");

        // Fill to DEPTH; the fifth offer is refused
        for (int i = 1; i <= 5; i++) begin
            drive(1, WIDTH'(i), OP_OR, 0, 0);
            cycle("fill_full");
        end
        drive(0, '0, '0, 0, 0);
        cycle("full_hold");

        // Full with push and pop offered: pop only
        drive(1, 4'h6, OP_NOR, 1, 0);
        cycle("full_pushpop");
        drive(0, '0, '0, 1, 0);
        repeat (4) cycle("drain_full");

        // Non-full steady state with simultaneous push/pop, pointers wrapping
        drive(1, 4'h1, OP_INC_B, 0, 0);
        cycle("pre_a");
        drive(1, 4'h2, OP_DEC_B, 0, 0);
        cycle("pre_b");
        for (int i = 0; i < 10; i++) begin
            drive(1, WIDTH'($urandom_range(0, 15)), SEL_W'($urandom_range(0, 12)), 1, 0);
            cycle("steady_pushpop");
        end
        drive(0, '0, '0, 1, 0);
        repeat (3) cycle("drain_steady");

        // Clear overrides a simultaneous push and pop
        drive(1, 4'hC, OP_NAND, 0, 0);
        cycle("clr_a");
        drive(1, 4'hD, OP_XNOR, 0, 0);
        cycle("clr_b");
        drive(1, 4'hF, OP_B_MINUS_A, 1, 1);
        cycle("clear");
        drive(0, '0, '0, 1, 0);
        repeat (2) cycle("after_clear");

        // Flag-relevant values: zero and negative results
        drive(1, 4'h0, OP_DEC_A, 0, 0);
        cycle("push_zero");
        drive(1, 4'h9, OP_NOT_A, 0, 0);
        cycle("push_neg");
        drive(0, '0, '0, 0, 0);
        cycle("zero_head");
        drive(0, '0, '0, 1, 0);
        repeat (3) cycle("drain_flags");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  WIDTH'($urandom_range(0, 15)),
                  SEL_W'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            cycle("random");
        end
        drive(0, '0, '0, 1, 0);
        repeat (6) cycle("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
